// File: rtl/rob_completion_tracker_if.sv
// rob_completion_tracker_if: allocation, completion, exception and retire signals of the pack tracker
interface rob_completion_tracker_if;
  logic       flush_i;
  logic       alloc_i;
  logic [1:0] alloc_slot_vld_i;
  logic [3:0] alloc_pack_o;
  logic       full_o;
  logic       alu0_complete;
  logic       alu1_complete;
  logic       eu2_complete;
  logic [4:0] alu0_rob_id;
  logic [4:0] alu1_rob_id;
  logic [4:0] eu2_rob_id;
  logic       excp_valid;
  logic [4:0] excp_rob;
  logic [4:0] excp_code;
  logic       commit_vld_o;
  logic [3:0] commit_pack_o;
  logic [1:0] commit_mask_o;
  logic       trap_vld_o;
  logic [4:0] trap_rob_o;
  logic [4:0] trap_code_o;
  logic [4:0] occupancy_o;
  modport master (
    output flush_i, alloc_i, alloc_slot_vld_i, alu0_complete, alu1_complete, eu2_complete,
           alu0_rob_id, alu1_rob_id, eu2_rob_id, excp_valid, excp_rob, excp_code,
    input  alloc_pack_o, full_o, commit_vld_o, commit_pack_o, commit_mask_o,
           trap_vld_o, trap_rob_o, trap_code_o, occupancy_o
  );
  modport slave (
    input  flush_i, alloc_i, alloc_slot_vld_i, alu0_complete, alu1_complete, eu2_complete,
           alu0_rob_id, alu1_rob_id, eu2_rob_id, excp_valid, excp_rob, excp_code,
    output alloc_pack_o, full_o, commit_vld_o, commit_pack_o, commit_mask_o,
           trap_vld_o, trap_rob_o, trap_code_o, occupancy_o
  );
endinterface

// File: rtl/rob_completion_tracker.sv
// rob_completion_tracker: 16-pack completion tracking with in-order retire and exception trap
module rob_completion_tracker (
  input logic cpu_clock_i,
  input logic cpu_resetn_i,
  rob_completion_tracker_if.slave bus
);
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_nx;
  logic [4:0] head, tail;
  logic [3:0] hi;
  logic [15:0] busy, excp, excp_slot;
  logic [15:0][1:0] done, mask, set;
  logic [15:0][4:0] ecode;
  logic full, head_rdy, do_commit, do_trap, do_alloc;
  logic commit_vld, trap_vld;
  logic [3:0] commit_pack;
  logic [1:0] commit_mask;
  logic [4:0] trap_rob, trap_code;
  assign hi = head[3:0];
  assign full = head[3:0] == tail[3:0] && head[4] != tail[4];
  assign head_rdy = busy[hi] && done[hi] == 2'b11;
  assign bus.alloc_pack_o = tail[3:0];
  assign bus.full_o = full || state == TRAP;
  assign bus.occupancy_o = tail - head;
  assign bus.commit_vld_o = commit_vld;
  assign bus.commit_pack_o = commit_pack;
  assign bus.commit_mask_o = commit_mask;
  assign bus.trap_vld_o = trap_vld;
  assign bus.trap_rob_o = trap_rob;
  assign bus.trap_code_o = trap_code;
  // a full queue may still accept a pack when the head retires in the same cycle
  always_comb begin
    do_commit = state == RUN && head_rdy && !excp[hi];
    do_trap = state == RUN && head_rdy && excp[hi];
    do_alloc = state == RUN && bus.alloc_i && (!full || do_commit);
    state_nx = bus.flush_i ? RUN : do_trap ? TRAP : state;
  end
  always_comb begin
    set = '0;
    if (bus.alu0_complete) set[bus.alu0_rob_id[4:1]][bus.alu0_rob_id[0]] = 1'b1;
    if (bus.alu1_complete) set[bus.alu1_rob_id[4:1]][bus.alu1_rob_id[0]] = 1'b1;
    if (bus.eu2_complete) set[bus.eu2_rob_id[4:1]][bus.eu2_rob_id[0]] = 1'b1;
  end
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i)
    if (!cpu_resetn_i) state <= RUN;
    else state <= state_nx;
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i)
    if (!cpu_resetn_i) begin
      head <= '0;
      tail <= '0;
      busy <= '0;
      done <= '0;
      mask <= '0;
      excp <= '0;
      excp_slot <= '0;
      ecode <= '0;
      commit_vld <= 1'b0;
      commit_pack <= '0;
      commit_mask <= '0;
      trap_vld <= 1'b0;
      trap_rob <= '0;
      trap_code <= '0;
    end else if (bus.flush_i) begin
      head <= '0;
      tail <= '0;
      busy <= '0;
      done <= '0;
      excp <= '0;
      commit_vld <= 1'b0;
      trap_vld <= 1'b0;
    end else begin
      commit_vld <= do_commit;
      trap_vld <= do_trap;
      if (do_commit) begin
        commit_pack <= hi;
        commit_mask <= mask[hi];
        head <= head + 5'd1;
      end
      if (do_trap) begin
        trap_rob <= {hi, excp_slot[hi]};
        trap_code <= ecode[hi];
      end
      if (do_alloc) tail <= tail + 5'd1;
      for (int i = 0; i < 16; i++) begin
        if (do_alloc && tail[3:0] == 4'(i)) begin
          busy[i] <= 1'b1;
          done[i] <= ~bus.alloc_slot_vld_i;
          mask[i] <= bus.alloc_slot_vld_i;
          excp[i] <= 1'b0;
        end else if (state == RUN) begin
          if (do_commit && hi == 4'(i)) busy[i] <= 1'b0;
          if (busy[i]) done[i] <= done[i] | set[i];
          if (busy[i] && !excp[i] && bus.excp_valid && bus.excp_rob[4:1] == 4'(i)) begin
            excp[i] <= 1'b1;
            excp_slot[i] <= bus.excp_rob[0];
            ecode[i] <= bus.excp_code;
          end
        end
      end
    end
endmodule
